mux2_tuple_rr_arbiter: RTL and testbench

- Two-requester arbiter sharing one tuple datapath (Bit, Bits[WIDTH]) between requester 0 and requester 1.
- Chooses a winner using round-robin with a burst limit and drives the 2:1 tuple mux select.
- Registers the selected tuple in a single-entry output stage with a valid/ready handshake.
- Sits in front of any consumer that previously took a raw Mux2xTupleBit_Bits2 output with an externally driven S.

---
 rtl/mux2_tuple_rr_arbiter_pkg.sv | 16 +
 rtl/mux2_tuple_rr_arbiter_if.sv | 36 +++
 rtl/Mux2xTupleBit_Bits2.sv | 17 +
 rtl/mux2_tuple_rr_arbiter.sv | 101 ++++++++++
 tb/tb_mux2_tuple_rr_arbiter.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/mux2_tuple_rr_arbiter_pkg.sv
// Shared types and constants for the two-requester tuple arbiter.
// Field 0 sits in bit 0 of the flattened tuple, field 1 above it.
package mux2_tuple_rr_arbiter_pkg;

  localparam int WIDTH     = 2;
  localparam int TUPLE_W   = WIDTH + 1;
  localparam int BURST_MIN = 1;
  localparam int BURST_LIM = 15;
  localparam int CNT_W     = 4;

  typedef struct packed {
    logic [WIDTH-1:0] f1;
    logic             f0;
  } tuple_t;

endpackage

// File: rtl/mux2_tuple_rr_arbiter_if.sv
// Requester, consumer and select signals of the tuple arbiter.
// slave is the arbiter side, master the requester/consumer side.
interface mux2_tuple_rr_arbiter_if;
  import mux2_tuple_rr_arbiter_pkg::*;

  logic             I_0__0;
  logic [WIDTH-1:0] I_0__1;
  logic             I_0_valid;
  logic             I_0_ready;
  logic             I_1__0;
  logic [WIDTH-1:0] I_1__1;
  logic             I_1_valid;
  logic             I_1_ready;
  logic             O__0;
  logic [WIDTH-1:0] O__1;
  logic             O_valid;
  logic             O_ready;
  logic             S;

  modport slave (
    input  I_0__0, I_0__1, I_0_valid,
    input  I_1__0, I_1__1, I_1_valid,
    output I_0_ready, I_1_ready,
    output O__0, O__1, O_valid, S,
    input  O_ready
  );

  modport master (
    output I_0__0, I_0__1, I_0_valid,
    output I_1__0, I_1__1, I_1_valid,
    input  I_0_ready, I_1_ready,
    input  O__0, O__1, O_valid, S,
    output O_ready
  );

endinterface

// File: rtl/Mux2xTupleBit_Bits2.sv
// Combinational 2:1 mux over a (Bit, Bits[WIDTH]) tuple.
module Mux2xTupleBit_Bits2
  import mux2_tuple_rr_arbiter_pkg::*;
(
  input  logic             I0__0,
  input  logic [WIDTH-1:0] I0__1,
  input  logic             I1__0,
  input  logic [WIDTH-1:0] I1__1,
  input  logic             S,
  output logic             O__0,
  output logic [WIDTH-1:0] O__1
);

  assign O__0 = S ? I1__0 : I0__0;
  assign O__1 = S ? I1__1 : I0__1;

endmodule

// File: rtl/mux2_tuple_rr_arbiter.sv
// Round-robin arbiter with burst limit feeding a registered tuple stage.
module mux2_tuple_rr_arbiter
  import mux2_tuple_rr_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic                    CLK,
  input  logic                    ASYNCRESET,
  mux2_tuple_rr_arbiter_if.slave  bus
);

  if (BURST_MAX < BURST_MIN || BURST_MAX > BURST_LIM) begin : g_bad_burst
    $error("BURST_MAX out of range");
  end

  localparam logic [CNT_W-1:0] L_MAX = CNT_W'(BURST_MAX);

  tuple_t           r_o;
  logic             r_valid;
  logic             r_s;
  logic [CNT_W-1:0] r_cnt;

  logic             w_load;
  logic             w_gnt_vld;
  logic             w_gnt;
  logic             w_none;
  logic             w_only0;
  logic             w_only1;
  logic             w_both;
  logic             w_mux_0;
  logic [WIDTH-1:0] w_mux_1;

  assign w_load  = !r_valid || bus.O_ready;
  assign w_none  = !w_load || (!bus.I_0_valid && !bus.I_1_valid);
  assign w_only0 = w_load && bus.I_0_valid && !bus.I_1_valid;
  assign w_only1 = w_load && !bus.I_0_valid && bus.I_1_valid;
  assign w_both  = w_load && bus.I_0_valid && bus.I_1_valid;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = r_s;
    unique case (1'b1)
      w_none: begin
        w_gnt_vld = 1'b0;
      end
      w_only0: begin
        w_gnt_vld = 1'b1;
        w_gnt     = 1'b0;
      end
      w_only1: begin
        w_gnt_vld = 1'b1;
        w_gnt     = 1'b1;
      end
      w_both: begin
        // Last winner keeps the bus until its burst is used up
        w_gnt_vld = 1'b1;
        w_gnt     = (r_cnt < L_MAX) ? r_s : !r_s;
      end
    endcase
  end

  assign bus.I_0_ready = !ASYNCRESET && w_gnt_vld && !w_gnt;
  assign bus.I_1_ready = !ASYNCRESET && w_gnt_vld && w_gnt;

  Mux2xTupleBit_Bits2 u_mux (
    .I0__0 (bus.I_0__0),
    .I0__1 (bus.I_0__1),
    .I1__0 (bus.I_1__0),
    .I1__1 (bus.I_1__1),
    .S     (w_gnt),
    .O__0  (w_mux_0),
    .O__1  (w_mux_1)
  );

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_o     <= '0;
      r_valid <= 1'b0;
      r_s     <= 1'b0;
      r_cnt   <= '0;
    end else if (w_gnt_vld) begin
      r_o.f0  <= w_mux_0;
      r_o.f1  <= w_mux_1;
      r_valid <= 1'b1;
      r_s     <= w_gnt;
      if (w_gnt != r_s) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt < L_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (w_load) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.O__0    = r_o.f0;
  assign bus.O__1    = r_o.f1;
  assign bus.O_valid = r_valid;
  assign bus.S       = r_s;

endmodule

// File: tb/tb_mux2_tuple_rr_arbiter.sv
// Directed bench: burst-4 arbiter plus a burst-1 copy for alternation.
module tb_mux2_tuple_rr_arbiter;
  import mux2_tuple_rr_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic rst;

  mux2_tuple_rr_arbiter_if ifa ();
  mux2_tuple_rr_arbiter_if ifb ();

  mux2_tuple_rr_arbiter #(.BURST_MAX(4)) u_dut_a (
    .CLK        (CLK),
    .ASYNCRESET (rst),
    .bus        (ifa)
  );

  mux2_tuple_rr_arbiter #(.BURST_MAX(1)) u_dut_b (
    .CLK        (CLK),
    .ASYNCRESET (rst),
    .bus        (ifb)
  );

  always #5 CLK = ~CLK;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rdy_a();
    return {30'd0, ifa.I_1_ready, ifa.I_0_ready};
  endfunction

  int ga[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int gr[5]  = '{1, 1, 1, 1, 0};

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ifa.I_0__0 = 1'b0; ifa.I_0__1 = 2'b01; ifa.I_0_valid = 1'b1;
    ifa.I_1__0 = 1'b1; ifa.I_1__1 = 2'b10; ifa.I_1_valid = 1'b1;
    ifa.O_ready = 1'b0;
    ifb.I_0__0 = 1'b0; ifb.I_0__1 = 2'b01; ifb.I_0_valid = 1'b0;
    ifb.I_1__0 = 1'b1; ifb.I_1__1 = 2'b10; ifb.I_1_valid = 1'b0;
    ifb.O_ready = 1'b1;
    #2;
    chk("rst_ovalid", 32'(ifa.O_valid), 32'd0);
    chk("rst_s", 32'(ifa.S), 32'd0);
    chk("rst_o0", 32'(ifa.O__0), 32'd0);
    chk("rst_o1", 32'(ifa.O__1), 32'd0);
    chk("rst_rdy", rdy_a(), 32'd0);

    @(negedge CLK);
    rst = 1'b0;
    ifa.I_0_valid = 1'b0;
    ifa.I_1_valid = 1'b1;
    ifa.O_ready = 1'b1;
    #1;
    chk("single_rdy", rdy_a(), 32'd2);
    @(posedge CLK); #1;
    chk("single_o0", 32'(ifa.O__0), 32'd1);
    chk("single_o1", 32'(ifa.O__1), 32'd2);
    chk("single_ovalid", 32'(ifa.O_valid), 32'd1);
    chk("single_s", 32'(ifa.S), 32'd1);

    @(negedge CLK);
    ifa.I_1__1 = 2'b11;
    @(posedge CLK); #1;
    chk("pre_rst_o1", 32'(ifa.O__1), 32'd3);
    chk("pre_rst_ovalid", 32'(ifa.O_valid), 32'd1);
    ifa.I_1_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_ovalid", 32'(ifa.O_valid), 32'd0);
    chk("mid_rst_o0", 32'(ifa.O__0), 32'd0);
    chk("mid_rst_o1", 32'(ifa.O__1), 32'd0);
    chk("mid_rst_s", 32'(ifa.S), 32'd0);
    @(negedge CLK);
    rst = 1'b0;
    ifa.I_1__1 = 2'b10;

    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      ifa.I_0_valid = 1'b1;
      ifa.I_1_valid = 1'b1;
      #1;
      chk("cont_rdy", rdy_a(), (ga[i] == 1) ? 32'd2 : 32'd1);
      @(posedge CLK); #1;
      chk("cont_s", 32'(ifa.S), 32'(ga[i]));
      chk("cont_o1", 32'(ifa.O__1), (ga[i] == 1) ? 32'd2 : 32'd1);
    end

    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      ifa.O_ready = 1'b0;
      #1;
      chk("stall_rdy", rdy_a(), 32'd0);
      @(posedge CLK); #1;
      chk("stall_o1", 32'(ifa.O__1), 32'd1);
      chk("stall_s", 32'(ifa.S), 32'd0);
      chk("stall_ovalid", 32'(ifa.O_valid), 32'd1);
    end

    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      ifa.O_ready = 1'b1;
      #1;
      chk("resume_rdy", rdy_a(), (gr[i] == 1) ? 32'd2 : 32'd1);
      @(posedge CLK); #1;
      chk("resume_s", 32'(ifa.S), 32'(gr[i]));
    end

    @(negedge CLK);
    ifa.I_0_valid = 1'b0;
    ifa.I_1_valid = 1'b0;
    #1;
    chk("drain_rdy", rdy_a(), 32'd0);
    @(posedge CLK); #1;
    chk("drain_ovalid", 32'(ifa.O_valid), 32'd0);
    chk("drain_o0", 32'(ifa.O__0), 32'd0);
    chk("drain_o1", 32'(ifa.O__1), 32'd1);

    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      ifa.I_0_valid = 1'b1;
      #1;
      chk("solo_rdy", rdy_a(), 32'd1);
      @(posedge CLK); #1;
      chk("solo_s", 32'(ifa.S), 32'd0);
    end
    @(negedge CLK);
    ifa.I_1_valid = 1'b1;
    #1;
    chk("sat_rdy", rdy_a(), 32'd2);
    @(posedge CLK); #1;
    chk("sat_s", 32'(ifa.S), 32'd1);
    @(negedge CLK);
    ifa.I_0_valid = 1'b0;
    ifa.I_1_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      ifb.I_0_valid = 1'b1;
      ifb.I_1_valid = 1'b1;
      @(posedge CLK); #1;
      chk("alt_s", 32'(ifb.S), 32'(i % 2));
      chk("alt_o0", 32'(ifb.O__0), 32'(i % 2));
      chk("alt_o1", 32'(ifb.O__1), (i % 2 == 1) ? 32'd2 : 32'd1);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
